rfile_sb: RTL and testbench

Parametrised register file with scoreboard for the pipelined core. It provides two combinational read ports and one write port, with register 0 hardwired to zero. After reset, an internal clear sequencer initialises every register, writing SP_INIT into the stack-pointer register. A per-register busy scoreboard lets decode detect RAW hazards against in-flight producers. It sits between decode, where reads and issue happen, and writeback.

---
 rtl/rfile_sb.sv | 112 +++++++++++
 tb/tb_rfile_sb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rfile_sb.sv
// rfile_sb: register file with RAW-hazard scoreboard for the pipelined core.
//
// Two combinational read ports, one write port, register 0 reads as zero.
// After reset a clear sequencer walks every register (one per cycle),
// loading SP_INIT into register SP_IDX and 0 elsewhere, then enters RUN
// and raises ready. A per-register busy bit is set on issue and cleared
// on writeback.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ra1/ra2         read addresses; rd1/rd2 data, rb1/rb2 busy flags
//   wa, wd, we      write port (write also clears busy[wa])
//   iss_v, iss_a    issue: marks iss_a busy
//   ready           high once the clear sequence has completed
//
// Optional feature: define RFILE_BYPASS_EN to forward a same-cycle write
// (data and a cleared busy flag) to the read ports.
module rfile_sb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned SP_IDX  = 29,
    parameter int unsigned SP_INIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  ra1,
    input  logic [REG_W-1:0]  ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rb1,
    output logic              rb2,
    input  logic [REG_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic              iss_v,
    input  logic [REG_W-1:0]  iss_a,
    output logic              ready
);

    localparam int unsigned         NREG      = 2 ** REG_W;
    localparam logic [REG_W-1:0]    SP_ADDR   = REG_W'(SP_IDX);
    localparam logic [REG_W-1:0]    LAST_ADDR = REG_W'(NREG - 1);
    localparam logic [DATA_W-1:0]   SP_VAL    = DATA_W'(SP_INIT);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state;
    state_t             state_next;
    logic [REG_W-1:0]   clr_idx;
    logic [DATA_W-1:0]  rf [NREG];
    logic [NREG-1:0]    busy;

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            CLEAR: if (clr_idx == LAST_ADDR) state_next = RUN;
            RUN:   ready = 1'b1;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end else begin
                // Issue is applied after writeback so a new producer wins.
                if (we)                    busy[wa]    <= 1'b0;
                if (iss_v && iss_a != '0)  busy[iss_a] <= 1'b1;
            end
        end
    end

    // Storage has no reset: the clear sequence initialises it, and reads
    // are forced to zero until that sequence is done.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            rf[clr_idx] <= (clr_idx == SP_ADDR) ? SP_VAL : '0;
        else if (we && wa != '0)
            rf[wa] <= wd;
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        rb1 = 1'b0;
        rb2 = 1'b0;
        if (state == RUN) begin
            if (ra1 != '0) rd1 = rf[ra1];
            if (ra2 != '0) rd2 = rf[ra2];
            rb1 = busy[ra1];
            rb2 = busy[ra2];
`ifdef RFILE_BYPASS_EN
            if (we && wa != '0 && ra1 == wa) begin
                rd1 = wd;
                rb1 = 1'b0;
            end
            if (we && wa != '0 && ra2 == wa) begin
                rd2 = wd;
                rb2 = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rfile_sb.sv
module tb_rfile_sb;

`ifdef RFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, iss_a = '0;
    logic [31:0] rd1, rd2, wd = '0;
    logic        rb1, rb2, we = 1'b0, iss_v = 1'b0, ready;

    int unsigned total = 0;
    int unsigned passed = 0;
    bit          chk_en = 1'b0;

    rfile_sb dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rb1(rb1), .rb2(rb2), .wa(wa), .wd(wd), .we(we), .iss_v(iss_v),
        .iss_a(iss_a), .ready(ready)
    );

    always #5 clk = ~clk;

    // Reference model: number of completed clear writes, register contents
    // and busy set.
    int          m_cnt = 0;
    logic [31:0] m_rf [32];
    bit          m_busy [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = '0;
            m_busy[i] = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (m_cnt < 32) begin
            m_rf[m_cnt] = (m_cnt == 29) ? 32'd1023 : 32'd0;
            m_cnt++;
        end else begin
            if (we && wa != 0) m_rf[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (iss_v && iss_a != 0) m_busy[iss_a] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (m_cnt != 32) return 32'd0;
        if (BYP && we && wa != 0 && ra == wa) return wd;
        if (ra == 0) return 32'd0;
        return m_rf[ra];
    endfunction

    function automatic logic exp_rb(input logic [4:0] ra);
        if (m_cnt != 32) return 1'b0;
        if (BYP && we && wa != 0 && ra == wa) return 1'b0;
        return m_busy[ra];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready), 32'(m_cnt == 32));
            chk("rd1", rd1, exp_rd(ra1));
            chk("rd2", rd2, exp_rd(ra2));
            chk("rb1", 32'(rb1), 32'(exp_rb(ra1)));
            chk("rb2", 32'(rb2), 32'(exp_rb(ra2)));
        end
    end

    // Inputs change 1 time unit after the falling edge; literal checks
    // follow 2 units later, still before the next rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        iss_v = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (ready) break;
        end
        chk(name, 32'(n), 32'd32);
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        #2;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rb1", 32'(rb1), 32'd0);
        tick();

        // Clear after reset.
        rst = 1'b0;
        ra1 = 5'd29;
        ra2 = 5'd3;
        wait_ready("clear_latency");
        #1;
        chk("sp_init", rd1, 32'd1023);
        chk("r3_cleared", rd2, 32'd0);

        // Reset mid-RUN drops ready at once.
        tick();
        rst = 1'b1;
        #1;
        chk("ready_falls_run", 32'(ready), 32'd0);
        tick();
        rst = 1'b0;
        repeat (10) @(posedge clk);
        tick();
        rst = 1'b1;
        #1;
        chk("ready_falls_clear", 32'(ready), 32'd0);
        tick();
        rst = 1'b0;
        we = 1'b1; wa = 5'd3; wd = 32'h55;
        wait_ready("clear_latency_2");
        tick();
        idle();
        ra1 = 5'd3;
        #2;
        chk("write_in_clear_lost", rd1, 32'd0);

        // Write/read and r0.
        tick();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        we = 1'b1; wa = 5'd0; wd = 32'h1234;
        tick();
        idle();
        ra1 = 5'd5; ra2 = 5'd0;
        #2;
        chk("r5_read", rd1, 32'hDEADBEEF);
        chk("r0_read", rd2, 32'd0);

        // Scoreboard on r7.
        tick();
        ra1 = 5'd7;
        iss_v = 1'b1; iss_a = 5'd7;
        #2;
        chk("busy_cycle_n", 32'(rb1), 32'd0);
        tick(); idle(); #2;
        chk("busy_n1", 32'(rb1), 32'd1);
        tick(); #2;
        chk("busy_n2", 32'(rb1), 32'd1);
        tick();
        we = 1'b1; wa = 5'd7; wd = 32'h77;
        #2;
        chk("busy_n3", 32'(rb1), BYP ? 32'd0 : 32'd1);
        tick(); idle(); #2;
        chk("busy_n4", 32'(rb1), 32'd0);
        tick();
        we = 1'b1; wa = 5'd7; wd = 32'h78;
        iss_v = 1'b1; iss_a = 5'd7;
        tick(); idle(); #2;
        chk("set_wins", 32'(rb1), 32'd1);
        chk("set_wins_data", rd1, 32'h78);

        // Bypass on r9.
        tick();
        we = 1'b1; wa = 5'd9; wd = 32'h11;
        tick();
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
        ra2 = 5'd9;
        #2;
        chk("bypass_same_cycle", rd2, BYP ? 32'hA5A5A5A5 : 32'h11);
        chk("bypass_rb2", 32'(rb2), 32'd0);
        tick(); idle(); #2;
        chk("bypass_next_cycle", rd2, 32'hA5A5A5A5);

        // Randomised traffic, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            tick();
            rst   = ($urandom_range(0, 249) == 0);
            we    = $urandom_range(0, 1);
            wa    = 5'($urandom);
            wd    = $urandom;
            iss_v = $urandom_range(0, 1);
            iss_a = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra1   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra2   = ($urandom_range(0, 3) == 0) ? iss_a : 5'($urandom);
        end
        tick();
        rst = 1'b0;
        idle();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
